reservation_station_mp: RTL and testbench
=========================================

# reservation_station_mp

Parametrised multi-port reservation station for the out-of-order core. It sits between the issue stage and a configurable bank of ALUs. It buffers up to `RS_SIZE` ALU instructions and captures operands from `NUM_CDB` result broadcast channels, including in the cycle an instruction is issued. It dispatches up to `NUM_ALU` ready instructions per cycle, oldest first, over valid/ready handshakes, and supports a full pipeline flush.

## Interface
Parameters:
- `RS_WIDTH`, 3, log2 of entry count; `RS_SIZE = 2**RS_WIDTH`.
- `ROB_WIDTH`, 4, ROB tag width.
- `REG_WIDTH`, 32, operand width.
- `OP_WIDTH`, 4, ALU opcode width.
- `NUM_ALU`, 2, dispatch ports (1..4).
- `NUM_CDB`, 2, broadcast channels (1..4).

Ports:
- `clk_in` input 1: the single clock; rising edge.
- `rst_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: when low, all state freezes and outputs hold.
- `flush` input 1: synchronous clear of all entries and dispatch registers.
- `issue` input 1: issue request; accepted only when `full` is low.
- `issue_opcode` input `OP_WIDTH`: opcode of the issued instruction.
- `issue_value_1`, `issue_value_2` input `REG_WIDTH`: operand values, used when the matching valid bit is high.
- `issue_tag_1`, `issue_tag_2` input `ROB_WIDTH`: producer tags, used when the matching valid bit is low.
- `issue_valid_1`, `issue_valid_2` input 1: operand value present at issue.
- `issue_rd_tag` input `ROB_WIDTH`: destination ROB tag.
- `cdb_valid` input `NUM_CDB`: per-channel broadcast strobe.
- `cdb_value` input `NUM_CDB*REG_WIDTH`: result values, channel k at bits `[k*REG_WIDTH +: REG_WIDTH]`.
- `cdb_tag` input `NUM_CDB*ROB_WIDTH`: result tags, same packing.
- `alu_valid` output `NUM_ALU`: dispatch register k holds an instruction.
- `alu_ready` input `NUM_ALU`: ALU k accepts this cycle.
- `alu_opcode` output `NUM_ALU*OP_WIDTH`: dispatched opcode, packed per port.
- `alu_lhs`, `alu_rhs` output `NUM_ALU*REG_WIDTH`: dispatched operands, packed per port.
- `alu_rd_tag` output `NUM_ALU*ROB_WIDTH`: dispatched destination tag, packed per port.
- `count` output `RS_WIDTH+1`: number of busy entries.
- `full` output 1: `count == RS_SIZE`.

## Operation
- **Entry state:** busy, opcode, two operands (value, tag, valid), rd tag, and an age-matrix row (`RS_SIZE` bits; bit j set means entry j is older).
- **Issue:**
  - Accepted when `issue & ~full & rdy_in & ~flush`.
  - The lowest-index free entry is allocated.
  - The new entry's age row is set to the current busy vector; other entries clear their bit for the new slot.
  - `issue` while `full` is dropped silently; upstream must stall.
- **Wake-up:**
  - Every busy entry compares each invalid operand tag against all valid CDB channels.
  - On a match, value is captured and valid is set.
  - If several channels match, the lowest channel index wins.
- **Issue bypass:** issued operands with valid=0 are compared against the same-cycle CDB and captured at allocation. A broadcast coincident with issue is therefore never lost.
- **Ready:** an entry is ready when busy and both operands are valid.
- **Dispatch:**
  - Dispatch register k can load when `~alu_valid[k] | alu_ready[k]`.
  - Loadable ports, in ascending k, receive the ready entries oldest first; the age matrix orders them.
  - At most `NUM_ALU` entries move per edge.
  - The chosen entries are freed at the same edge.
  - A port that does not load while handshaking (`alu_ready[k]` high with no ready entry) clears `alu_valid[k]`.
- **Count:** `count` next = `count` + accepted issue − entries dispatched.
- **Flush:**
  - Clears all busy bits, all `alu_valid`, and `count`.
  - Overrides issue, CDB and dispatch in the same cycle.
  - Also acts with `rdy_in` low.
- **Reset:**
  - Asynchronous on `rst_in` low.
  - All outputs go to 0: `alu_valid`, `alu_opcode`, `alu_lhs`, `alu_rhs`, `alu_rd_tag`, `count`, `full`.
  - All busy, valid and age bits go to 0.
  - Reset asserted mid-operation discards all contents immediately.

## Timing
- Issue with both operands valid, sampled at edge N: the entry is ready after N, and `alu_valid` rises after edge N+1. This is 2-edge issue-to-dispatch.
- CDB wake-up at edge N makes the entry eligible for dispatch at N+1. There is no combinational CDB-to-ALU path.
- Freed slots are visible to `full` after the freeing edge only. Issue and dispatch on the same edge never target the same slot.
- `alu_*` data stays stable while `alu_valid[k] & ~alu_ready[k]`.
- `full` and `count` are registered-derived; there is no combinational path from `issue`.

## Configuration
- `RS_AGE_SELECT_EN`:
  - Defined: age-matrix, oldest-first selection as above.
  - Undefined: the age matrix is not built, and selection is lowest-index-first among ready entries. All other behaviour is identical.

## Test plan
- **Reset:** reset mid-operation with 5 busy entries, `rst_in` low asynchronously → `count`=0 and `alu_valid`=0 immediately, with no clock needed.
- **Back-to-back issue:** issue ADD 3+4 then SUB 10−2, both operands valid → `alu_valid[0]` at edge 2 with lhs=3 rhs=4, `alu_valid[1]` at edge 3 with lhs=10 rhs=2.
- **Issue bypass:** issue with tag_1=5 pending while CDB0 broadcasts tag 5 value 0x1234 in the same cycle → dispatched with lhs=0x1234.
- **Fill and stall:** issue 8 dependent ops while holding `alu_ready`=0 → `full`=1, `count`=8, and a 9th issue is ignored. Then CDB tag 2 wakes entries 6 and 1 (entry 6 issued first) with `alu_ready`=1 → entry 6 goes to port 0 and entry 1 to port 1 (with `RS_AGE_SELECT_EN`).
- **Backpressure:** `alu_ready[0]`=0 for 3 cycles → port 0 data unchanged and the other ready entries use port 1.
- **Flush:** `flush` with `count`=6 and `issue` high in the same cycle → `count`=0 and `alu_valid`=0 next edge, with no entry allocated.

Source files
------------

// File: rtl/reservation_station_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reservation_station_mp_if                                       |
// | Purpose  : Bundles the issue bus, the result broadcast (CDB) channels and  |
// |            the ALU dispatch handshakes of reservation_station_mp.           |
// | Modports : master - issue stage / CDB / ALU side (drives issue, CDB and    |
// |                     alu_ready; observes dispatch, count and full)          |
// |            slave  - the reservation station itself                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface reservation_station_mp_if #(
  parameter int RS_WIDTH  = 3,
  parameter int ROB_WIDTH = 4,
  parameter int REG_WIDTH = 32,
  parameter int OP_WIDTH  = 4,
  parameter int NUM_ALU   = 2,
  parameter int NUM_CDB   = 2
);
  // issue bus
  logic                         issue;
  logic [OP_WIDTH-1:0]          issue_opcode;
  logic [REG_WIDTH-1:0]         issue_value_1;
  logic [REG_WIDTH-1:0]         issue_value_2;
  logic [ROB_WIDTH-1:0]         issue_tag_1;
  logic [ROB_WIDTH-1:0]         issue_tag_2;
  logic                         issue_valid_1;
  logic                         issue_valid_2;
  logic [ROB_WIDTH-1:0]         issue_rd_tag;
  // result broadcast channels, channel k at [k*W +: W]
  logic [NUM_CDB-1:0]           cdb_valid;
  logic [NUM_CDB*REG_WIDTH-1:0] cdb_value;
  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_tag;
  // dispatch ports, port k at [k*W +: W]
  logic [NUM_ALU-1:0]           alu_valid;
  logic [NUM_ALU-1:0]           alu_ready;
  logic [NUM_ALU*OP_WIDTH-1:0]  alu_opcode;
  logic [NUM_ALU*REG_WIDTH-1:0] alu_lhs;
  logic [NUM_ALU*REG_WIDTH-1:0] alu_rhs;
  logic [NUM_ALU*ROB_WIDTH-1:0] alu_rd_tag;
  // occupancy
  logic [RS_WIDTH:0]            count;
  logic                         full;

  modport master (
    output issue, issue_opcode, issue_value_1, issue_value_2, issue_tag_1,
           issue_tag_2, issue_valid_1, issue_valid_2, issue_rd_tag,
           cdb_valid, cdb_value, cdb_tag, alu_ready,
    input  alu_valid, alu_opcode, alu_lhs, alu_rhs, alu_rd_tag, count, full
  );

  modport slave (
    input  issue, issue_opcode, issue_value_1, issue_value_2, issue_tag_1,
           issue_tag_2, issue_valid_1, issue_valid_2, issue_rd_tag,
           cdb_valid, cdb_value, cdb_tag, alu_ready,
    output alu_valid, alu_opcode, alu_lhs, alu_rhs, alu_rd_tag, count, full
  );
endinterface
`default_nettype wire

// File: rtl/reservation_station_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reservation_station_mp                                          |
// | Purpose  : Multi-port ALU reservation station. Buffers up to 2**RS_WIDTH    |
// |            instructions, wakes operands from NUM_CDB broadcast channels     |
// |            (including same-cycle bypass at issue) and dispatches up to      |
// |            NUM_ALU ready instructions per cycle over valid/ready ports.     |
// | Ports    : clk_in  - clock, rising edge                                    |
// |            rst_in  - asynchronous reset, active low                         |
// |            rdy_in  - global enable; low freezes all state                   |
// |            flush   - synchronous clear of entries and dispatch registers    |
// |            bus     - reservation_station_mp_if.slave (issue, CDB, ALU,      |
// |                      count, full)                                           |
// | Config   : `define RS_AGE_SELECT_EN selects oldest-first dispatch through   |
// |            an age matrix; otherwise lowest-index-first among ready entries. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module reservation_station_mp #(
  parameter int RS_WIDTH  = 3,
  parameter int ROB_WIDTH = 4,
  parameter int REG_WIDTH = 32,
  parameter int OP_WIDTH  = 4,
  parameter int NUM_ALU   = 2,
  parameter int NUM_CDB   = 2
) (
  input  wire logic               clk_in,
  input  wire logic               rst_in,
  input  wire logic               rdy_in,
  input  wire logic               flush,
  reservation_station_mp_if.slave bus
);
  localparam int                c_RS_SIZE    = 2 ** RS_WIDTH;
  localparam logic [RS_WIDTH:0] c_FULL_COUNT = (RS_WIDTH+1)'(c_RS_SIZE);

  // entry storage
  logic [c_RS_SIZE-1:0] r_busy, r_ok1, r_ok2;
  logic [OP_WIDTH-1:0]  r_op   [c_RS_SIZE];
  logic [REG_WIDTH-1:0] r_val1 [c_RS_SIZE];
  logic [REG_WIDTH-1:0] r_val2 [c_RS_SIZE];
  logic [ROB_WIDTH-1:0] r_tag1 [c_RS_SIZE];
  logic [ROB_WIDTH-1:0] r_tag2 [c_RS_SIZE];
  logic [ROB_WIDTH-1:0] r_rd   [c_RS_SIZE];
`ifdef RS_AGE_SELECT_EN
  // r_age[i][j] set: entry j is older than entry i
  logic [c_RS_SIZE-1:0] r_age  [c_RS_SIZE];
`endif

  // dispatch registers
  logic [NUM_ALU-1:0]           r_alu_valid;
  logic [NUM_ALU*OP_WIDTH-1:0]  r_alu_opcode;
  logic [NUM_ALU*REG_WIDTH-1:0] r_alu_lhs, r_alu_rhs;
  logic [NUM_ALU*ROB_WIDTH-1:0] r_alu_rd_tag;
  logic [RS_WIDTH:0]            r_count;

  logic [NUM_CDB-1:0]           w_cdb_valid;
  logic [NUM_CDB*REG_WIDTH-1:0] w_cdb_value;
  logic [NUM_CDB*ROB_WIDTH-1:0] w_cdb_tag;
  logic                         w_full, w_issue_acc;
  logic [RS_WIDTH-1:0]          w_free_idx;
  logic [c_RS_SIZE-1:0]         w_ready, w_cand, w_disp_oh, w_hit1, w_hit2;
  logic [REG_WIDTH-1:0]         w_wake1 [c_RS_SIZE];
  logic [REG_WIDTH-1:0]         w_wake2 [c_RS_SIZE];
  logic                         w_byp_hit1, w_byp_hit2, w_pick_ok;
  logic [REG_WIDTH-1:0]         w_byp_val1, w_byp_val2;
  logic [NUM_ALU-1:0]           w_load_en, w_sel_vld;
  logic [RS_WIDTH-1:0]          w_sel_idx [NUM_ALU];
  logic [RS_WIDTH:0]            w_n_disp;

  assign w_cdb_valid = bus.cdb_valid;
  assign w_cdb_value = bus.cdb_value;
  assign w_cdb_tag   = bus.cdb_tag;

  assign w_full      = (r_count == c_FULL_COUNT);
  assign w_issue_acc = bus.issue & ~w_full & rdy_in & ~flush;
  assign w_ready     = r_busy & r_ok1 & r_ok2;
  assign w_load_en   = ~r_alu_valid | bus.alu_ready;

  // {hit, value} for a tag; scanning high to low lets the lowest channel win
  function automatic logic [REG_WIDTH:0] f_cdb_match(input logic [ROB_WIDTH-1:0] tag);
    logic [REG_WIDTH:0] res;
    res = '0;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (w_cdb_valid[c] && (w_cdb_tag[c*ROB_WIDTH +: ROB_WIDTH] == tag))
        res = {1'b1, w_cdb_value[c*REG_WIDTH +: REG_WIDTH]};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < c_RS_SIZE; i++) begin
      {w_hit1[i], w_wake1[i]} = f_cdb_match(r_tag1[i]);
      {w_hit2[i], w_wake2[i]} = f_cdb_match(r_tag2[i]);
    end
    {w_byp_hit1, w_byp_val1} = f_cdb_match(bus.issue_tag_1);
    {w_byp_hit2, w_byp_val2} = f_cdb_match(bus.issue_tag_2);
  end

  // lowest-index free slot; only meaningful while not full
  always_comb begin
    w_free_idx = '0;
    for (int i = c_RS_SIZE-1; i >= 0; i--)
      if (!r_busy[i]) w_free_idx = RS_WIDTH'(i);
  end

  // Ports in ascending order each take the best remaining ready entry. With
  // the age matrix only one candidate has no older candidate left; without it
  // the descending scan leaves the lowest index selected.
  always_comb begin
    w_cand    = w_ready;
    w_disp_oh = '0;
    w_sel_vld = '0;
    w_pick_ok = 1'b0;
    w_n_disp  = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      w_sel_idx[k] = '0;
      if (w_load_en[k]) begin
        for (int i = c_RS_SIZE-1; i >= 0; i--) begin
`ifdef RS_AGE_SELECT_EN
          w_pick_ok = ((r_age[i] & w_cand) == '0);
`else
          w_pick_ok = 1'b1;
`endif
          if (w_cand[i] && w_pick_ok) begin
            w_sel_vld[k] = 1'b1;
            w_sel_idx[k] = RS_WIDTH'(i);
          end
        end
        if (w_sel_vld[k]) begin
          w_cand[w_sel_idx[k]]    = 1'b0;
          w_disp_oh[w_sel_idx[k]] = 1'b1;
        end
      end
    end
    for (int i = 0; i < c_RS_SIZE; i++)
      w_n_disp = w_n_disp + (RS_WIDTH+1)'(w_disp_oh[i]);
  end

  // entry array
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy <= '0;
      r_ok1  <= '0;
      r_ok2  <= '0;
      for (int i = 0; i < c_RS_SIZE; i++) begin
        r_op[i]   <= '0;
        r_val1[i] <= '0;
        r_val2[i] <= '0;
        r_tag1[i] <= '0;
        r_tag2[i] <= '0;
        r_rd[i]   <= '0;
`ifdef RS_AGE_SELECT_EN
        r_age[i]  <= '0;
`endif
      end
    end else if (flush) begin
      r_busy <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < c_RS_SIZE; i++) begin
        if (w_issue_acc && (w_free_idx == RS_WIDTH'(i))) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= bus.issue_opcode;
          r_rd[i]   <= bus.issue_rd_tag;
          r_tag1[i] <= bus.issue_tag_1;
          r_tag2[i] <= bus.issue_tag_2;
          r_val1[i] <= bus.issue_valid_1 ? bus.issue_value_1 : w_byp_val1;
          r_ok1[i]  <= bus.issue_valid_1 | w_byp_hit1;
          r_val2[i] <= bus.issue_valid_2 ? bus.issue_value_2 : w_byp_val2;
          r_ok2[i]  <= bus.issue_valid_2 | w_byp_hit2;
`ifdef RS_AGE_SELECT_EN
          r_age[i]  <= r_busy;
`endif
        end else begin
          if (w_disp_oh[i]) r_busy[i] <= 1'b0;
          if (!r_ok1[i] && w_hit1[i]) begin
            r_val1[i] <= w_wake1[i];
            r_ok1[i]  <= 1'b1;
          end
          if (!r_ok2[i] && w_hit2[i]) begin
            r_val2[i] <= w_wake2[i];
            r_ok2[i]  <= 1'b1;
          end
`ifdef RS_AGE_SELECT_EN
          // the newly allocated slot is younger than everyone
          if (w_issue_acc) r_age[i][w_free_idx] <= 1'b0;
`endif
        end
      end
    end
  end

  // dispatch registers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_alu_valid  <= '0;
      r_alu_opcode <= '0;
      r_alu_lhs    <= '0;
      r_alu_rhs    <= '0;
      r_alu_rd_tag <= '0;
      r_count      <= '0;
    end else if (flush) begin
      r_alu_valid <= '0;
      r_count     <= '0;
    end else if (rdy_in) begin
      for (int k = 0; k < NUM_ALU; k++) begin
        if (w_sel_vld[k]) begin
          r_alu_valid[k]                           <= 1'b1;
          r_alu_opcode[k*OP_WIDTH +: OP_WIDTH]     <= r_op[w_sel_idx[k]];
          r_alu_lhs[k*REG_WIDTH +: REG_WIDTH]      <= r_val1[w_sel_idx[k]];
          r_alu_rhs[k*REG_WIDTH +: REG_WIDTH]      <= r_val2[w_sel_idx[k]];
          r_alu_rd_tag[k*ROB_WIDTH +: ROB_WIDTH]   <= r_rd[w_sel_idx[k]];
        end else if (bus.alu_ready[k]) begin
          r_alu_valid[k] <= 1'b0;
        end
      end
      r_count <= r_count + (RS_WIDTH+1)'(w_issue_acc) - w_n_disp;
    end
  end

  assign bus.alu_valid  = r_alu_valid;
  assign bus.alu_opcode = r_alu_opcode;
  assign bus.alu_lhs    = r_alu_lhs;
  assign bus.alu_rhs    = r_alu_rhs;
  assign bus.alu_rd_tag = r_alu_rd_tag;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
endmodule
`default_nettype wire

// File: tb/tb_reservation_station_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reservation_station_mp                                       |
// | Purpose  : Directed self-checking bench for reservation_station_mp with    |
// |            hand-computed expected values.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_reservation_station_mp;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk_in = ~clk_in;

  reservation_station_mp_if #(
    .RS_WIDTH(3), .ROB_WIDTH(4), .REG_WIDTH(32),
    .OP_WIDTH(4), .NUM_ALU(2), .NUM_CDB(2)
  ) bus ();

  reservation_station_mp #(
    .RS_WIDTH(3), .ROB_WIDTH(4), .REG_WIDTH(32),
    .OP_WIDTH(4), .NUM_ALU(2), .NUM_CDB(2)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  // which fill-test entry lands on which port depends on the selection policy
`ifdef RS_AGE_SELECT_EN
  localparam logic [3:0]  EXP_P0_RD = 4'd6;
  localparam logic [3:0]  EXP_P1_RD = 4'd10;
  localparam logic [31:0] EXP_P0_RHS = 32'h106;
`else
  localparam logic [3:0]  EXP_P0_RD = 4'd10;
  localparam logic [3:0]  EXP_P1_RD = 4'd6;
  localparam logic [31:0] EXP_P0_RHS = 32'hAA;
`endif

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] op, input logic ok1, input logic [31:0] v1,
                           input logic [3:0] t1, input logic ok2, input logic [31:0] v2,
                           input logic [3:0] t2, input logic [3:0] rd);
    bus.issue         = 1'b1;
    bus.issue_opcode  = op;
    bus.issue_valid_1 = ok1;
    bus.issue_value_1 = v1;
    bus.issue_tag_1   = t1;
    bus.issue_valid_2 = ok2;
    bus.issue_value_2 = v2;
    bus.issue_tag_2   = t2;
    bus.issue_rd_tag  = rd;
  endtask

  task automatic set_cdb(input logic [1:0] vld, input logic [3:0] t0, input logic [31:0] x0,
                         input logic [3:0] t1, input logic [31:0] x1);
    bus.cdb_valid = vld;
    bus.cdb_tag   = {t1, t0};
    bus.cdb_value = {x1, x0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    bus.issue = 1'b0; bus.issue_opcode = '0; bus.issue_rd_tag = '0;
    bus.issue_value_1 = '0; bus.issue_value_2 = '0;
    bus.issue_tag_1 = '0; bus.issue_tag_2 = '0;
    bus.issue_valid_1 = 1'b0; bus.issue_valid_2 = 1'b0;
    bus.alu_ready = 2'b00;
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);

    // reset
    #2 rst_in = 1'b0;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_valid", bus.alu_valid, 0);
    check("rst_full",  bus.full, 0);
    check("rst_lhs",   bus.alu_lhs, 0);
    step(); step();
    rst_in = 1'b1;

    // back-to-back issue, ALUs stalled
    set_issue(4'd1, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd1);
    step();
    check("b2b_cnt1", bus.count, 1);
    check("b2b_v1",   bus.alu_valid, 2'b00);
    set_issue(4'd2, 1'b1, 32'd10, 4'd0, 1'b1, 32'd2, 4'd0, 4'd2);
    step();
    check("b2b_v2",   bus.alu_valid, 2'b01);
    check("b2b_lhs0", bus.alu_lhs[31:0], 3);
    check("b2b_rhs0", bus.alu_rhs[31:0], 4);
    check("b2b_op0",  bus.alu_opcode[3:0], 1);
    check("b2b_rd0",  bus.alu_rd_tag[3:0], 1);
    bus.issue = 1'b0;
    step();
    check("b2b_v3",   bus.alu_valid, 2'b11);
    check("b2b_lhs1", bus.alu_lhs[63:32], 10);
    check("b2b_rhs1", bus.alu_rhs[63:32], 2);
    check("b2b_hold", bus.alu_lhs[31:0], 3);
    check("b2b_cnt3", bus.count, 0);
    bus.alu_ready = 2'b11;
    step();
    check("b2b_drain", bus.alu_valid, 2'b00);

    // issue bypass: both channels carry tag 5, channel 0 must win
    set_issue(4'd3, 1'b0, 32'd0, 4'd5, 1'b1, 32'd7, 4'd0, 4'd3);
    set_cdb(2'b11, 4'd5, 32'h1234, 4'd5, 32'hDEAD);
    step();
    check("byp_v1",  bus.alu_valid, 2'b00);
    check("byp_cnt", bus.count, 1);
    bus.issue = 1'b0;
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    step();
    check("byp_v2",  bus.alu_valid, 2'b01);
    check("byp_lhs", bus.alu_lhs[31:0], 32'h1234);
    check("byp_rhs", bus.alu_rhs[31:0], 7);
    step();

    // wake-up from channel 1; channel 0 carries the tag but is not valid
    set_issue(4'd4, 1'b1, 32'h11, 4'd0, 1'b0, 32'd0, 4'd9, 4'd4);
    step();
    check("wk_cnt", bus.count, 1);
    bus.issue = 1'b0;
    set_cdb(2'b10, 4'd9, 32'hBAD, 4'd9, 32'h99);
    step();
    check("wk_nocomb", bus.alu_valid, 2'b00);
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    step();
    check("wk_v",   bus.alu_valid, 2'b01);
    check("wk_lhs", bus.alu_lhs[31:0], 32'h11);
    check("wk_rhs", bus.alu_rhs[31:0], 32'h99);
    step();

    // rdy_in low freezes: issue is not accepted
    rdy_in = 1'b0;
    set_issue(4'd5, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd5);
    step();
    check("frz_cnt", bus.count, 0);
    bus.issue = 1'b0;
    rdy_in = 1'b1;
    step();
    check("frz_v", bus.alu_valid, 2'b00);

    // fill and stall: slot k waits on tag 3, except slot 1 (tag 7) and slot 6 (tag 2)
    bus.alu_ready = 2'b00;
    for (int k = 0; k < 8; k++) begin
      set_issue(4'(k), 1'b0, 32'd0, (k == 1) ? 4'd7 : (k == 6) ? 4'd2 : 4'd3,
                1'b1, 32'h100 + 32'(k), 4'd0, 4'(k));
      step();
    end
    check("fill_cnt",  bus.count, 8);
    check("fill_full", bus.full, 1);
    set_issue(4'hF, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'hF);
    step();
    check("fill_drop", bus.count, 8);
    bus.issue = 1'b0;
    set_cdb(2'b01, 4'd7, 32'h77, 4'd0, 32'd0);
    step();
    check("fill_v0", bus.alu_valid, 2'b00);
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    step();
    check("fill_v1",   bus.alu_valid, 2'b01);
    check("fill_lhs1", bus.alu_lhs[31:0], 32'h77);
    check("fill_rd1",  bus.alu_rd_tag[3:0], 1);
    check("fill_cnt7", bus.count, 7);
    // re-occupies slot 1, younger than slot 6
    set_issue(4'hA, 1'b0, 32'd0, 4'd2, 1'b1, 32'hAA, 4'd0, 4'd10);
    step();
    check("fill_refull", bus.full, 1);
    bus.issue = 1'b0;
    set_cdb(2'b10, 4'd0, 32'd0, 4'd2, 32'h222);
    step();
    check("fill_hold_v",   bus.alu_valid, 2'b01);
    check("fill_hold_lhs", bus.alu_lhs[31:0], 32'h77);
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    bus.alu_ready = 2'b11;
    step();
    check("ord_v",    bus.alu_valid, 2'b11);
    check("ord_rd0",  bus.alu_rd_tag[3:0], EXP_P0_RD);
    check("ord_rd1",  bus.alu_rd_tag[7:4], EXP_P1_RD);
    check("ord_rhs0", bus.alu_rhs[31:0], EXP_P0_RHS);
    check("ord_lhs1", bus.alu_lhs[63:32], 32'h222);
    check("ord_cnt",  bus.count, 6);

    // backpressure on port 0 for three cycles
    bus.alu_ready = 2'b10;
    set_cdb(2'b01, 4'd3, 32'h333, 4'd0, 32'd0);
    step();
    check("bp1_v",   bus.alu_valid, 2'b01);
    check("bp1_rd0", bus.alu_rd_tag[3:0], EXP_P0_RD);
    set_cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    step();
    check("bp2_v",   bus.alu_valid, 2'b11);
    check("bp2_rd1", bus.alu_rd_tag[7:4], 0);
    check("bp2_lhs1", bus.alu_lhs[63:32], 32'h333);
    check("bp2_lhs0", bus.alu_lhs[31:0], 32'h222);
    check("bp2_cnt", bus.count, 5);
    step();
    check("bp3_rd1", bus.alu_rd_tag[7:4], 2);
    check("bp3_rd0", bus.alu_rd_tag[3:0], EXP_P0_RD);
    check("bp3_cnt", bus.count, 4);

    // flush with issue in the same cycle
    bus.alu_ready = 2'b00;
    set_issue(4'hB, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd11);
    step();
    step();
    check("fl_cnt6", bus.count, 6);
    flush = 1'b1;
    bus.alu_ready = 2'b11;
    step();
    check("fl_cnt",  bus.count, 0);
    check("fl_v",    bus.alu_valid, 2'b00);
    check("fl_full", bus.full, 0);
    flush = 1'b0;
    bus.issue = 1'b0;
    step();
    check("fl_noalloc", bus.alu_valid, 2'b00);
    check("fl_cnt2",    bus.count, 0);

    // asynchronous reset with five busy entries
    bus.alu_ready = 2'b00;
    set_issue(4'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd6, 4'd0, 4'd1);
    step();
    for (int k = 0; k < 5; k++) begin
      set_issue(4'd2, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0, 4'(k));
      step();
    end
    bus.issue = 1'b0;
    check("ar_cnt5", bus.count, 5);
    check("ar_v",    bus.alu_valid, 2'b01);
    #2 rst_in = 1'b0;
    #1;
    check("ar_cnt0", bus.count, 0);
    check("ar_v0",   bus.alu_valid, 2'b00);
    check("ar_lhs",  bus.alu_lhs[31:0], 0);
    #2 rst_in = 1'b1;
    step();
    check("ar_post", bus.count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
